wddl_phase_ctrl: RTL and testbench

//  Sequencer for a WDDL dual-rail combinational cloud built from wddl_* gate cells.

---
 rtl/wddl_pkg.sv | 24 ++
 rtl/wddl_rail_checker.sv | 18 +
 rtl/wddl_phase_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_wddl_phase_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wddl_pkg.sv
// wddl_pkg: shared types and helpers for the WDDL phase sequencer.
// Holds the phase encoding, counter width and dual-rail expansion.
package wddl_pkg;

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_PRE  = 2'd1,
    PH_EVAL = 2'd2
  } wddl_phase_e;

  // Phase counter width; supports up to 256 cycles per phase.
  localparam int PHASE_CNT_W = 8;

  // Widest single-ended operand the dual-rail helper handles.
  localparam int DR_MAX_W = 32;

  // Expand to dual rail: low half true rails, high half false rails.
  function automatic logic [2*DR_MAX_W-1:0] to_dual_rail(
    input logic [DR_MAX_W-1:0] data
  );
    return {~data, data};
  endfunction

endpackage

// File: rtl/wddl_rail_checker.sv
// wddl_rail_checker: combinational WDDL rail fault detection.
// Flags precharge leakage and non-complementary result pairs.
module wddl_rail_checker #(
  parameter int RWIDTH = 1
) (
  input  logic [RWIDTH-1:0] res_t_i,
  input  logic [RWIDTH-1:0] res_f_i,
  output logic              leak_o,
  output logic              ncomp_o
);

  // Any rail high while the cloud should be precharged to zero.
  assign leak_o  = |(res_t_i | res_f_i);

  // Any pair that is 00 or 11 is not a valid dual-rail value.
  assign ncomp_o = |(~(res_t_i ^ res_f_i));

endmodule

// File: rtl/wddl_phase_ctrl.sv
// wddl_phase_ctrl: precharge/evaluate sequencer for a WDDL dual-rail cloud.
// Define WDDL_RAIL_CHECK_EN to build the rail-fault checker driving err_o.
module wddl_phase_ctrl
  import wddl_pkg::*;
#(
  parameter int WIDTH    = 2,
  parameter int RWIDTH   = 1,
  parameter int PRE_CYC  = 1,
  parameter int EVAL_CYC = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [WIDTH-1:0]  in_data_i,
  output logic              prechrg_o,
  output logic [WIDTH-1:0]  dr_t_o,
  output logic [WIDTH-1:0]  dr_f_o,
  input  logic [RWIDTH-1:0] res_t_i,
  input  logic [RWIDTH-1:0] res_f_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [RWIDTH-1:0] out_data_o,
  output logic              err_o
);

  localparam logic [PHASE_CNT_W-1:0] PRE_LD  = PHASE_CNT_W'(PRE_CYC - 1);
  localparam logic [PHASE_CNT_W-1:0] EVAL_LD = PHASE_CNT_W'(EVAL_CYC - 1);

  wddl_phase_e             state_q, state_d;
  logic [PHASE_CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]        data_q, data_d;
  logic                    out_valid_q, out_valid_d;
  logic [RWIDTH-1:0]       out_data_q, out_data_d;
  logic                    prechrg_q, prechrg_d;
  logic [WIDTH-1:0]        dr_t_q, dr_t_d;
  logic [WIDTH-1:0]        dr_f_q, dr_f_d;

  logic                    accept;
  logic                    cnt_zero;
  logic                    pre_last;
  logic                    capture;

  logic [2*DR_MAX_W-1:0]   dr_pair;
  logic [WIDTH-1:0]        rail_t;
  logic [WIDTH-1:0]        rail_f;
  logic                    unused_dr;

  assign in_ready_o = (state_q == PH_IDLE)
                    & (~out_valid_q | out_ready_i);
  assign accept     = in_valid_i & in_ready_o;
  assign cnt_zero   = (cnt_q == '0);
  assign pre_last   = (state_q == PH_PRE) & cnt_zero;
  assign capture    = (state_q == PH_EVAL) & cnt_zero;

  assign dr_pair    = to_dual_rail(DR_MAX_W'(data_q));
  assign rail_t     = dr_pair[WIDTH-1:0];
  assign rail_f     = dr_pair[DR_MAX_W +: WIDTH];
  assign unused_dr  = ^dr_pair;

  // Phase sequencing, token latch and result capture.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    out_valid_d = out_valid_q & ~out_ready_i;
    out_data_d  = out_data_q;
    unique case (1'b1)
      (state_q == PH_IDLE): begin
        if (accept) begin
          state_d = PH_PRE;
          data_d  = in_data_i;
          cnt_d   = PRE_LD;
        end
      end
      (state_q == PH_PRE): begin
        if (cnt_zero) begin
          state_d = PH_EVAL;
          cnt_d   = EVAL_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      (state_q == PH_EVAL): begin
        if (cnt_zero) begin
          state_d     = PH_IDLE;
          out_valid_d = 1'b1;
          out_data_d  = res_t_i;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = PH_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Phase outputs decoded from the next state so they leave a flop.
  always_comb begin
    prechrg_d = 1'b1;
    dr_t_d    = '0;
    dr_f_d    = '0;
    if (state_d == PH_EVAL) begin
      prechrg_d = 1'b0;
      dr_t_d    = rail_t;
      dr_f_d    = rail_f;
    end
  end

  // State, datapath and phase output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= PH_IDLE;
      cnt_q       <= '0;
      data_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      prechrg_q   <= 1'b1;
      dr_t_q      <= '0;
      dr_f_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      prechrg_q   <= prechrg_d;
      dr_t_q      <= dr_t_d;
      dr_f_q      <= dr_f_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign prechrg_o   = prechrg_q;
  assign dr_t_o      = dr_t_q;
  assign dr_f_o      = dr_f_q;

`ifdef WDDL_RAIL_CHECK_EN
  logic leak;
  logic ncomp;
  logic pend_q, pend_d;
  logic err_q, err_d;

  wddl_rail_checker #(
    .RWIDTH (RWIDTH)
  ) u_chk (
    .res_t_i (res_t_i),
    .res_f_i (res_f_i),
    .leak_o  (leak),
    .ncomp_o (ncomp)
  );

  // Pending leak flag per token; error registered alongside the result.
  always_comb begin
    pend_d = pend_q;
    err_d  = err_q;
    if (accept) begin
      pend_d = 1'b0;
    end else if (pre_last && leak) begin
      pend_d = 1'b1;
    end
    if (capture) begin
      err_d = pend_q | ncomp;
    end
  end

  // Fault flag registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end

  assign err_o = err_q;
`else
  logic unused_chk;
  assign unused_chk = ^{res_f_i, pre_last};
  assign err_o      = 1'b0;
`endif

endmodule

// File: tb/tb_wddl_phase_ctrl.sv
// tb_wddl_phase_ctrl: scoreboard bench for the WDDL phase sequencer.
// Models a single WDDL OR gate as the cloud, with rail fault injection.
`timescale 1ns/1ps
module tb_wddl_phase_ctrl;

  localparam int P   = 1;
  localparam int E   = 2;
  localparam int LAT = P + E;
`ifdef WDDL_RAIL_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_i;
  logic       in_valid_i;
  logic       in_ready_o;
  logic [1:0] in_data_i;
  logic       prechrg_o;
  logic [1:0] dr_t_o;
  logic [1:0] dr_f_o;
  logic [0:0] res_t_i;
  logic [0:0] res_f_i;
  logic       out_valid_o;
  logic       out_ready_i;
  logic [0:0] out_data_o;
  logic       err_o;

  wddl_phase_ctrl #(
    .WIDTH    (2),
    .RWIDTH   (1),
    .PRE_CYC  (P),
    .EVAL_CYC (E)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .prechrg_o   (prechrg_o),
    .dr_t_o      (dr_t_o),
    .dr_f_o      (dr_f_o),
    .res_t_i     (res_t_i),
    .res_f_i     (res_f_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic d;
    logic e;
    int   acc;
  } exp_t;

  exp_t       sb[$];
  int         rise[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         cur_acc = -1000;
  logic [1:0] cur_data = 2'b00;
  int         mode = 0;
  bit         rnd_rdy = 1'b0;
  logic       prev_v = 1'b0;

  // WDDL OR cloud: t = a_t|b_t, f = a_f&b_f; mode 1 shorts both
  // rails high during evaluate, mode 2 leaks t during precharge.
  logic force_t, force_f;
  always_comb begin
    force_t = (mode == 1 && !prechrg_o) || (mode == 2 && prechrg_o);
    force_f = (mode == 1 && !prechrg_o);
  end
  assign res_t_i[0] = (dr_t_o[0] | dr_t_o[1]) | force_t;
  assign res_f_i[0] = (dr_f_o[0] & dr_f_o[1]) | force_f;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               nm, act, req, $time);
    end
  endtask

  int         k;
  bit         drive;
  bit         idle_m;
  bit         exp_v;
  bit         exp_rdy;
  logic [1:0] inv_data;

  // Monitor: phase outputs, handshake and scoreboard compare.
  always @(negedge clk) begin
    if (!rst_i) begin
      k        = cyc - cur_acc;
      drive    = (k >= P) && (k < LAT);
      idle_m   = (k < 0) || (k >= LAT);
      exp_v    = (sb.size() > 0) && (sb[0].acc + LAT <= cyc);
      exp_rdy  = idle_m && (!exp_v || out_ready_i);
      inv_data = ~cur_data;
      chk("prechrg", prechrg_o, !drive);
      chk("dr_t", dr_t_o, drive ? cur_data : 2'b00);
      chk("dr_f", dr_f_o, drive ? inv_data : 2'b00);
      chk("out_valid", out_valid_o, exp_v);
      chk("in_ready", in_ready_o, exp_rdy);
      if (exp_v) begin
        chk("out_data", out_data_o, sb[0].d);
        chk("err", err_o, sb[0].e);
      end
      if (out_valid_o && !prev_v) rise.push_back(cyc);
      prev_v = out_valid_o;
      if (exp_v && out_ready_i) void'(sb.pop_front());
    end else begin
      prev_v = 1'b0;
    end
  end

  // Random downstream backpressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_rdy) out_ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic [1:0] d, input int m);
    bit done;
    done = 1'b0;
    while (cyc < cur_acc + LAT) begin
      @(posedge clk);
      #1;
    end
    mode       = m;
    in_valid_i = 1'b1;
    in_data_i  = d;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready_o) begin
        sb.push_back('{d: (m == 1) ? 1'b1 : (|d),
                       e: (m != 0) && CHK_EN,
                       acc: cyc + 1});
        cur_acc  = cyc + 1;
        cur_data = d;
        done     = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid_i = 1'b0;
    in_data_i  = 2'($urandom);
    chk("accept_timeout", done, 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", sb.size(), 0);
    mode = 0;
  endtask

  initial begin
    rst_i       = 1'b1;
    in_valid_i  = 1'b0;
    in_data_i   = 2'b00;
    out_ready_i = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_prechrg", prechrg_o, 1'b1);
    chk("rst_dr_t", dr_t_o, 2'b00);
    chk("rst_dr_f", dr_f_o, 2'b00);
    chk("rst_valid", out_valid_o, 1'b0);
    chk("rst_ready", in_ready_o, 1'b1);
    chk("rst_data", out_data_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;

    send(2'b01, 0);
    drain();
    send(2'b00, 0);
    drain();

    out_ready_i = 1'b0;
    send(2'b10, 0);
    repeat (LAT + 5) begin
      @(posedge clk);
      #1;
    end
    out_ready_i = 1'b1;
    drain();

    rise.delete();
    send(2'b11, 0);
    send(2'b00, 0);
    drain();
    chk("b2b_rises", rise.size(), 2);
    if (rise.size() >= 2) chk("b2b_gap", rise[1] - rise[0], LAT + 1);

    send(2'b00, 1);
    drain();
    send(2'b00, 2);
    drain();
    send(2'b01, 0);
    drain();

    send(2'b11, 0);
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    #1;
    chk("mid_rst_prechrg", prechrg_o, 1'b1);
    chk("mid_rst_dr_t", dr_t_o, 2'b00);
    chk("mid_rst_dr_f", dr_f_o, 2'b00);
    chk("mid_rst_valid", out_valid_o, 1'b0);
    sb.delete();
    cur_acc = -1000;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    send(2'b10, 0);
    drain();

    rnd_rdy = 1'b1;
    for (int t = 0; t < 60; t++) begin
      repeat ($urandom_range(0, 3)) begin
        in_data_i = 2'($urandom);
        @(posedge clk);
        #1;
      end
      send(2'($urandom), int'($urandom_range(0, 2)));
    end
    rnd_rdy     = 1'b0;
    out_ready_i = 1'b1;
    drain();
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
